// File: rtl/pe_tile_accumulator.sv
// Accumulates consecutive 6x6 PE result tiles for one (OD, x, y) across input channels and presents the sum on a valid/ready port.
// Optional PE_ACC_SAT_EN: saturating narrow plus a sat_o flag; otherwise results are two's-complement truncated.
module pe_tile_accumulator #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int MAX_ID = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic [4:0]                     cfg_id_count_i,
  input  logic                           in_valid_i,
  input  logic [0:5][0:5][DATA_W-1:0]    in_tile_i,
  input  logic [7:0]                     in_od_i,
  input  logic [8:0]                     in_x_i,
  input  logic [8:0]                     in_y_i,
  input  logic                           in_size_type_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [0:5][0:5][DATA_W-1:0]    out_tile_o,
  output logic [0:5][0:5]                out_mask_o,
  output logic [7:0]                     out_od_o,
  output logic [8:0]                     out_x_o,
  output logic [8:0]                     out_y_o,
  output logic                           stall_o,
  output logic                           ovf_o,
  output logic                           tag_err_o
`ifdef PE_ACC_SAT_EN
  ,
  output logic                           sat_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                           state_q, state_d;
  logic [0:5][0:5][ACC_W-1:0]       acc_q, acc_d;
  logic [4:0]                       cnt_q, cnt_d, n_q, n_d;
  logic [7:0]                       od_q, od_d, out_od_q, out_od_d;
  logic [8:0]                       x_q, x_d, y_q, y_d;
  logic [8:0]                       out_x_q, out_x_d, out_y_q, out_y_d;
  logic                             type_q, type_d;
  logic                             out_valid_q, out_valid_d;
  logic [0:5][0:5][DATA_W-1:0]      out_tile_q, out_tile_d;
  logic [0:5][0:5]                  out_mask_q, out_mask_d;
  logic                             ovf_q, ovf_d, tag_err_q, tag_err_d;
  logic                             sat_q, sat_d;

  logic                             out_free, tag_match, load_out;
  logic [4:0]                       cfg_n, cnt_inc;
  logic [7:0]                       cur_od;
  logic [8:0]                       cur_x, cur_y;
  logic                             cur_type;
  logic [0:5][0:5]                  cur_mask;
  logic [0:5][0:5][ACC_W-1:0]       sum, src;

  function automatic logic fits(input logic [ACC_W-1:0] v);
    return (&v[ACC_W-1:DATA_W-1]) || (~|v[ACC_W-1:DATA_W-1]);
  endfunction

  function automatic logic [DATA_W-1:0] narrow(input logic [ACC_W-1:0] v);
`ifdef PE_ACC_SAT_EN
    if (fits(v))        return v[DATA_W-1:0];
    else if (v[ACC_W-1]) return {1'b1, {(DATA_W-1){1'b0}}};
    else                return {1'b0, {(DATA_W-1){1'b1}}};
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  always_comb begin
    out_free  = !out_valid_q || out_ready_i;
    cnt_inc   = cnt_q + 5'd1;
    tag_match = (in_od_i == od_q) && (in_x_i == x_q) && (in_y_i == y_q);
    if (cfg_id_count_i == 5'd0)            cfg_n = 5'd1;
    else if (int'(cfg_id_count_i) > MAX_ID) cfg_n = 5'(MAX_ID);
    else                                    cfg_n = cfg_id_count_i;

    // A tile starting in IDLE carries its own tags; later stages use the latched ones.
    cur_od   = (state_q == IDLE) ? in_od_i        : od_q;
    cur_x    = (state_q == IDLE) ? in_x_i         : x_q;
    cur_y    = (state_q == IDLE) ? in_y_i         : y_q;
    cur_type = (state_q == IDLE) ? in_size_type_i : type_q;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        cur_mask[i][j] = !cur_type || (i < 4 && j < 4);
        sum[i][j] = ((state_q == IDLE) ? '0 : acc_q[i][j])
                  + {{(ACC_W-DATA_W){in_tile_i[i][j][DATA_W-1]}}, in_tile_i[i][j]};
        src[i][j] = (state_q == HOLD) ? acc_q[i][j] : sum[i][j];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    od_d        = od_q;
    x_d         = x_q;
    y_d         = y_q;
    type_d      = type_q;
    out_valid_d = out_valid_q;
    out_tile_d  = out_tile_q;
    out_mask_d  = out_mask_q;
    out_od_d    = out_od_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    ovf_d       = ovf_q;
    tag_err_d   = tag_err_q;
    sat_d       = sat_q;
    load_out    = 1'b0;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      sat_d       = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          n_d    = cfg_n;
          od_d   = in_od_i;
          x_d    = in_x_i;
          y_d    = in_y_i;
          type_d = in_size_type_i;
          acc_d  = sum;
          cnt_d  = 5'd1;
          if (cfg_n != 5'd1)  state_d  = ACCUM;
          else if (out_free)  load_out = 1'b1;
          else                state_d  = HOLD;
        end
      end
      ACCUM: begin
        if (in_valid_i && !tag_match) begin
          tag_err_d = 1'b1;
        end else if (in_valid_i) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if (cnt_inc == n_q) begin
            if (out_free) begin
              load_out = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (in_valid_i) ovf_d = 1'b1;
        if (out_free) begin
          load_out = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_out) begin
      out_valid_d = 1'b1;
      out_od_d    = cur_od;
      out_x_d     = cur_x;
      out_y_d     = cur_y;
      out_mask_d  = cur_mask;
      sat_d       = 1'b0;
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          out_tile_d[i][j] = cur_mask[i][j] ? narrow(src[i][j]) : '0;
          if (cur_mask[i][j] && !fits(src[i][j])) sat_d = 1'b1;
        end
      end
    end

    // Abort wins over everything, including a same-cycle input tile.
    if (clear_i) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_tile_d  = '0;
      out_mask_d  = '0;
      out_od_d    = '0;
      out_x_d     = '0;
      out_y_d     = '0;
      ovf_d       = 1'b0;
      tag_err_d   = 1'b0;
      sat_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      od_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      type_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_tile_q  <= '0;
      out_mask_q  <= '0;
      out_od_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      ovf_q       <= 1'b0;
      tag_err_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      od_q        <= od_d;
      x_q         <= x_d;
      y_q         <= y_d;
      type_q      <= type_d;
      out_valid_q <= out_valid_d;
      out_tile_q  <= out_tile_d;
      out_mask_q  <= out_mask_d;
      out_od_q    <= out_od_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      ovf_q       <= ovf_d;
      tag_err_q   <= tag_err_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_tile_o  = out_tile_q;
  assign out_mask_o  = out_mask_q;
  assign out_od_o    = out_od_q;
  assign out_x_o     = out_x_q;
  assign out_y_o     = out_y_q;
  assign stall_o     = (state_q == HOLD);
  assign ovf_o       = ovf_q;
  assign tag_err_o   = tag_err_q;
`ifdef PE_ACC_SAT_EN
  assign sat_o       = sat_q;
`else
  logic unused_sat;
  assign unused_sat  = sat_q;
`endif

endmodule

// File: tb/tb_pe_tile_accumulator.sv
// Directed-vector bench for pe_tile_accumulator: single tiles, multi-channel sums, HOLD/overflow, tag errors, wrap/saturate, reset and clear.
module tb_pe_tile_accumulator;

  typedef logic [0:5][0:5][15:0] tile_t;

  logic        clk = 1'b0;
  logic        reset, clear_i;
  logic [4:0]  cfg_id_count_i;
  logic        in_valid_i;
  tile_t       in_tile_i;
  logic [7:0]  in_od_i;
  logic [8:0]  in_x_i, in_y_i;
  logic        in_size_type_i;
  logic        out_valid_o, out_ready_i;
  tile_t       out_tile_o;
  logic [0:5][0:5] out_mask_o;
  logic [7:0]  out_od_o;
  logic [8:0]  out_x_o, out_y_o;
  logic        stall_o, ovf_o, tag_err_o;
`ifdef PE_ACC_SAT_EN
  logic        sat_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pe_tile_accumulator dut (
    .clk(clk), .reset(reset), .clear_i(clear_i), .cfg_id_count_i(cfg_id_count_i),
    .in_valid_i(in_valid_i), .in_tile_i(in_tile_i), .in_od_i(in_od_i),
    .in_x_i(in_x_i), .in_y_i(in_y_i), .in_size_type_i(in_size_type_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tile_o(out_tile_o),
    .out_mask_o(out_mask_o), .out_od_o(out_od_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
    .stall_o(stall_o), .ovf_o(ovf_o), .tag_err_o(tag_err_o)
`ifdef PE_ACC_SAT_EN
    , .sat_o(sat_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tile_t exp_tile(input logic [15:0] v, input logic ty);
    tile_t t;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        t[i][j] = (!ty || (i < 4 && j < 4)) ? v : 16'h0;
    return t;
  endfunction

  function automatic logic [35:0] exp_mask(input logic ty);
    logic [0:5][0:5] m;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        m[i][j] = !ty || (i < 4 && j < 4);
    return m;
  endfunction

  // Called at a falling edge; presents one tile for exactly one rising edge.
  task automatic send_tile(input logic [15:0] v, input logic [7:0] od,
                           input logic [8:0] x, input logic [8:0] y, input logic ty);
    in_valid_i = 1'b1;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        in_tile_i[i][j] = v;
    in_od_i = od;
    in_x_i = x;
    in_y_i = y;
    in_size_type_i = ty;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear_i = 1'b0; cfg_id_count_i = 5'd1; in_valid_i = 1'b0;
    in_tile_i = '0; in_od_i = '0; in_x_i = '0; in_y_i = '0; in_size_type_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid_o, 0);
    check("rst_tile", out_tile_o, 0);
    check("rst_mask", out_mask_o, 0);
    check("rst_flags", {stall_o, ovf_o, tag_err_o}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single-channel tile, full 6x6 region.
    cfg_id_count_i = 5'd1;
    send_tile(16'd5, 8'd1, 9'd0, 9'd0, 1'b0);
    check("n1_valid", out_valid_o, 1);
    check("n1_tile", out_tile_o, exp_tile(16'd5, 1'b0));
    check("n1_mask", out_mask_o, exp_mask(1'b0));
    @(negedge clk);
    check("n1_consumed", out_valid_o, 0);

    // Four channels, 4x4 region; cfg change after the first tile must not matter.
    cfg_id_count_i = 5'd4;
    send_tile(16'd100, 8'd3, 9'd8, 9'd12, 1'b1);
    cfg_id_count_i = 5'd1;
    send_tile(16'd100, 8'd3, 9'd8, 9'd12, 1'b1);
    send_tile(16'd100, 8'd3, 9'd8, 9'd12, 1'b1);
    check("n4_not_yet", out_valid_o, 0);
    send_tile(16'd100, 8'd3, 9'd8, 9'd12, 1'b1);
    check("n4_valid", out_valid_o, 1);
    check("n4_tile", out_tile_o, exp_tile(16'd400, 1'b1));
    check("n4_mask", out_mask_o, exp_mask(1'b1));
    check("n4_tags", {out_od_o, out_x_o, out_y_o}, {8'd3, 9'd8, 9'd12});
    @(negedge clk);

    // Backpressure: second sum completes while the first is unread.
    out_ready_i = 1'b0;
    cfg_id_count_i = 5'd2;
    send_tile(16'd10, 8'd1, 9'd0, 9'd0, 1'b0);
    send_tile(16'd10, 8'd1, 9'd0, 9'd0, 1'b0);
    check("hold_first", out_tile_o, exp_tile(16'd20, 1'b0));
    send_tile(16'd7, 8'd2, 9'd0, 9'd0, 1'b0);
    send_tile(16'd7, 8'd2, 9'd0, 9'd0, 1'b0);
    check("hold_stall", stall_o, 1);
    check("hold_keeps_first", out_tile_o, exp_tile(16'd20, 1'b0));
    check("hold_no_ovf_yet", ovf_o, 0);
    send_tile(16'd99, 8'd2, 9'd0, 9'd0, 1'b0);
    check("hold_ovf", ovf_o, 1);
    out_ready_i = 1'b1;
    @(negedge clk);
    check("drain_valid", out_valid_o, 1);
    check("drain_second", out_tile_o, exp_tile(16'd14, 1'b0));
    check("drain_od", out_od_o, 8'd2);
    check("drain_stall", stall_o, 0);
    @(negedge clk);
    check("drain_empty", out_valid_o, 0);

    // Tag mismatch mid-accumulation is ignored and flagged.
    cfg_id_count_i = 5'd3;
    send_tile(16'd11, 8'd3, 9'd1, 9'd2, 1'b0);
    send_tile(16'd11, 8'd4, 9'd1, 9'd2, 1'b0);
    check("tag_err", tag_err_o, 1);
    send_tile(16'd11, 8'd3, 9'd1, 9'd2, 1'b0);
    check("tag_not_yet", out_valid_o, 0);
    send_tile(16'd11, 8'd3, 9'd1, 9'd2, 1'b0);
    check("tag_valid", out_valid_o, 1);
    check("tag_sum", out_tile_o, exp_tile(16'd33, 1'b0));
    @(negedge clk);

    // 4 x 30000 = 120000 overflows 16 bits.
    cfg_id_count_i = 5'd4;
    repeat (4) send_tile(16'd30000, 8'd0, 9'd0, 9'd0, 1'b0);
    check("big_valid", out_valid_o, 1);
`ifdef PE_ACC_SAT_EN
    check("big_sat", out_tile_o, exp_tile(16'h7FFF, 1'b0));
    check("big_sat_flag", sat_o, 1);
`else
    check("big_wrap", out_tile_o, exp_tile(16'hD4C0, 1'b0));
`endif
    @(negedge clk);

    // Asynchronous reset mid-accumulation with a tile pending.
    out_ready_i = 1'b0;
    cfg_id_count_i = 5'd1;
    send_tile(16'd9, 8'd5, 9'd0, 9'd0, 1'b0);
    cfg_id_count_i = 5'd2;
    send_tile(16'd9, 8'd5, 9'd0, 9'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_tile", out_tile_o, 0);
    check("arst_flags", {stall_o, ovf_o, tag_err_o}, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready_i = 1'b1;
    cfg_id_count_i = 5'd0;
    send_tile(16'd7, 8'd0, 9'd0, 9'd0, 1'b0);
    check("arst_next", out_tile_o, exp_tile(16'd7, 1'b0));
    @(negedge clk);

    // Synchronous clear while in HOLD, with a tile presented in the same cycle.
    out_ready_i = 1'b0;
    cfg_id_count_i = 5'd1;
    send_tile(16'd9, 8'd0, 9'd0, 9'd0, 1'b0);
    send_tile(16'd2, 8'd0, 9'd0, 9'd0, 1'b0);
    check("clr_hold", stall_o, 1);
    send_tile(16'd2, 8'd0, 9'd0, 9'd0, 1'b0);
    check("clr_pre_ovf", ovf_o, 1);
    clear_i = 1'b1;
    send_tile(16'd3, 8'd0, 9'd0, 9'd0, 1'b0);
    clear_i = 1'b0;
    check("clr_valid", out_valid_o, 0);
    check("clr_tile", {out_tile_o, out_mask_o}, 0);
    check("clr_flags", {stall_o, ovf_o, tag_err_o}, 0);
    @(negedge clk);
    check("clr_ignored_in", out_valid_o, 0);
    out_ready_i = 1'b1;
    cfg_id_count_i = 5'd0;
    send_tile(16'd7, 8'd0, 9'd0, 9'd0, 1'b1);
    check("clr_next", out_tile_o, exp_tile(16'd7, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
